// File: rtl/fact_if.sv
// ============================================================================
// Module      : fact_if
// Description : Handshake/select bundle between the factorial control FSM
//               and the fact_datapath register stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fact_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] n_in;
    logic [1:0]       WAsel;
    logic [1:0]       WBsel;
    logic [1:0]       next_s;
    logic [1:0]       cur_s;
    logic             z;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (
        output start, clear, n_in, WAsel, WBsel, next_s,
        input  cur_s, z, done, result, ovf
    );

    modport slave (
        input  start, clear, n_in, WAsel, WBsel, next_s,
        output cur_s, z, done, result, ovf
    );
endinterface

`default_nettype wire

// File: rtl/fact_datapath.sv
// ============================================================================
// Module      : fact_datapath
// Description : State register, operand A and accumulator B for the factorial
//               engine. Optional macro FACT_SAT_EN saturates B on overflow
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fact_datapath #(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    fact_if.slave     bus
);

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        QX = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_ovf;
    logic [WIDTH-1:0]       w_op_a;
    logic [WIDTH-1:0]       w_a_dec;
    logic [2*WIDTH-1:0]     w_prod;
    logic                   w_prod_ovf;
    logic [WIDTH-1:0]       w_b_mul;

    // Next state: Q0 only advances on start, Q2 may be cleared, 11 recovers to Q0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Q0:      w_state_nxt = bus.start ? state_t'(bus.next_s) : Q0;
            Q1:      w_state_nxt = state_t'(bus.next_s);
            Q2:      w_state_nxt = bus.clear ? Q0 : state_t'(bus.next_s);
            default: w_state_nxt = Q0;
        endcase
        if (w_state_nxt == QX) begin
            w_state_nxt = Q0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= Q0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A==0 multiplies by one so that 0! evaluates to 1.
    assign w_op_a     = (r_a == '0) ? WIDTH'(1) : r_a;
    assign w_a_dec    = (r_a == '0) ? '0 : (r_a - WIDTH'(1));
    assign w_prod     = (2*WIDTH)'(r_b) * (2*WIDTH)'(w_op_a);
    assign w_prod_ovf = |w_prod[2*WIDTH-1:WIDTH];

`ifdef FACT_SAT_EN
    assign w_b_mul = w_prod_ovf ? '1 : w_prod[WIDTH-1:0];
`else
    assign w_b_mul = w_prod[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (bus.WAsel)
                2'd1:    r_a <= w_a_dec;
                2'd2:    r_a <= bus.n_in;
                default: r_a <= r_a;
            endcase
            case (bus.WBsel)
                2'd0: begin
                    r_b   <= WIDTH'(1);
                    r_ovf <= 1'b0;
                end
                2'd1: begin
                    r_b <= w_b_mul;
                    if (w_prod_ovf) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: r_b <= r_b;
            endcase
        end
    end

    assign bus.cur_s  = r_state;
    assign bus.z      = (r_a[WIDTH-1:1] == '0);
    assign bus.done   = (r_state == Q2);
    assign bus.result = r_b;
    assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fact_datapath.sv
// ============================================================================
// Module      : tb_fact_datapath
// Description : Self-checking bench; emulates the control FSM and compares
//               against a plain-arithmetic factorial model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fact_datapath;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fact_if #(.WIDTH(WIDTH)) bus ();

    fact_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_fact(input int n, output longint res, output bit ov);
        longint p = 1;
        for (int i = n; i >= 2; i--) p = p * i;
        ov = (p >= 65536);
`ifdef FACT_SAT_EN
        res = ov ? 65535 : p;
`else
        res = p % 65536;
`endif
    endfunction

    // Control FSM behaviour, evaluated from the settled DUT outputs.
    task automatic drive_fsm();
        case (bus.cur_s)
            2'd0: begin bus.WAsel = 2'd2; bus.WBsel = 2'd0; bus.next_s = 2'd1; end
            2'd1: begin bus.WAsel = 2'd1; bus.WBsel = 2'd1; bus.next_s = bus.z ? 2'd2 : 2'd1; end
            2'd2: begin bus.WAsel = 2'd0; bus.WBsel = 2'd2; bus.next_s = 2'd2; end
            default: begin bus.WAsel = 2'd0; bus.WBsel = 2'd2; bus.next_s = 2'd0; end
        endcase
    endtask

    task automatic tick();
        drive_fsm();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit hold_start);
        longint exp_res;
        bit     exp_ov;
        int     lat;
        int     exp_lat;
        ref_fact(n, exp_res, exp_ov);
        exp_lat = (n < 1) ? 1 : n;
        bus.n_in  = WIDTH'(n);
        bus.start = 1'b1;
        tick();
        if (!hold_start) bus.start = 1'b0;
        check($sformatf("a_load_n%0d", n), dut.r_a, n);
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
            check($sformatf("a_seq_n%0d_e%0d", n, lat), dut.r_a, (n - lat < 0) ? 0 : n - lat);
        end
        check($sformatf("latency_n%0d", n), lat, exp_lat);
        check($sformatf("result_n%0d", n), bus.result, exp_res);
        check($sformatf("ovf_n%0d", n), bus.ovf, exp_ov);
        bus.start = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        check("clear_to_q0", bus.cur_s, 0);
        bus.clear = 1'b0;
    endtask

    initial begin
        longint exp_res;
        bit     exp_ov;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.clear  = 1'b0;
        bus.n_in   = '0;
        bus.WAsel  = 2'd0;
        bus.WBsel  = 2'd0;
        bus.next_s = 2'd0;
        tick();
        tick();
        check("rst_cur_s", bus.cur_s, 0);
        check("rst_result", bus.result, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_done", bus.done, 0);
        check("rst_z", bus.z, 1);
        reset = 1'b0;
        tick();

        run(5, 1'b0);
        do_clear();
        run(0, 1'b0);
        do_clear();
        run(1, 1'b0);
        do_clear();
        run(9, 1'b0);
        do_clear();

        // Reset in the middle of Q1 with start asserted in the reset cycle.
        bus.n_in  = WIDTH'(7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("midq1_state", bus.cur_s, 1);
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        check("midrst_cur_s", bus.cur_s, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_ovf", bus.ovf, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        run(4, 1'b0);

        // Q2 holds while clear stays low.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("q2_hold_result", bus.result, 24);
            check("q2_hold_done", bus.done, 1);
        end
        do_clear();

        // start held high through the whole computation.
        run(6, 1'b1);
        do_clear();

        // Illegal next_s from the FSM recovers to Q0.
        bus.n_in  = WIDTH'(6);
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.WAsel  = 2'd1;
        bus.WBsel  = 2'd1;
        bus.next_s = 2'd3;
        @(posedge clk);
        #1;
        check("illegal_next_s", bus.cur_s, 0);
        tick();

        // Overflow flag clears on the next computation's B load.
        run(12, 1'b0);
        do_clear();
        tick();
        check("ovf_cleared_q0", bus.ovf, 0);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(0, 12);
            run(n, $urandom_range(0, 1) == 1);
            ref_fact(n, exp_res, exp_ov);
            repeat ($urandom_range(0, 4)) tick();
            check("rand_hold_result", bus.result, exp_res);
            do_clear();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
